// File: rtl/divider_counter_pkg.sv
// Shared constants for the divider_counter slice: FSM encodings, default sizing, stop phase.
// The divider width follows ONE_FORTH_COUNTER_EN (one-forth stage present when defined).
package divider_counter_pkg;

  localparam int unsigned DefPrescale  = 4;
  localparam int unsigned DefPrescaleW = 8;
  localparam int unsigned DefTickW     = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StRun      = 2'd1;
  localparam state_t StStopping = 2'd2;

  // Bit 0 is the one-half divider, bit 1 (when built) the one-forth divider.
`ifdef ONE_FORTH_COUNTER_EN
  localparam int unsigned DivW = 2;
`else
  localparam int unsigned DivW = 1;
`endif

  localparam logic [DivW-1:0] StopPhase = '0;

endpackage

// File: rtl/divider_prescaler.sv
// Tick prescaler: counts 0..Prescale-1 while enabled and flags the wrap cycle as a tick.
module divider_prescaler #(
  parameter int unsigned Prescale  = 4,
  parameter int unsigned PrescaleW = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PrescaleW-1:0] Last = PrescaleW'(Prescale - 1);

  logic [PrescaleW-1:0] count_q, count_d;

  // A clear in the same cycle wins, so no tick escapes a resynchronisation.
  assign tick_o = en_i && !clr_i && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tick_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/divider_counter.sv
// Divide-by-2 / divide-by-4 counter generator with run-control FSM and pipe-enable strobes.
// Macro ONE_FORTH_COUNTER_EN compiles in the one-forth divider and its ports.
module divider_counter
  import divider_counter_pkg::*;
#(
  parameter int unsigned PRESCALE   = DefPrescale,
  parameter int unsigned PRESCALE_W = DefPrescaleW,
  parameter int unsigned TICK_W     = DefTickW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              sync_clear,
  output logic              signal_to_one_half,
  output logic              one_half_pipe_enable,
`ifdef ONE_FORTH_COUNTER_EN
  output logic              signal_to_one_forth,
  output logic              one_forth_pipe_enable,
`endif
  output logic              running,
  output logic [TICK_W-1:0] tick_count
);

  state_t            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [DivW-1:0]   div_en_q, div_en_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              presc_clr, presc_en, tick, sclr, at_stop_phase;

  assign at_stop_phase = (div_q == StopPhase);
  assign sclr          = (state_q == StRun) && sync_clear;

  // Once STOPPING sees the all-zero phase, the pending tick is suppressed.
  always_comb begin
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    case (state_q)
      StRun: begin
        presc_en  = 1'b1;
        presc_clr = sync_clear;
      end
      StStopping: begin
        presc_en  = !at_stop_phase;
        presc_clr = at_stop_phase;
      end
      default: presc_clr = 1'b1;
    endcase
  end

  divider_prescaler #(
    .Prescale  (PRESCALE),
    .PrescaleW (PRESCALE_W)
  ) u_prescaler (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .tick_o (tick)
  );

  always_comb begin
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    state_d    = state_q;

    if (sclr) begin
      div_d      = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      div_d[0]   = ~div_q[0];
`ifdef ONE_FORTH_COUNTER_EN
      if (div_q[0]) div_d[1] = ~div_q[1];
`endif
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    // Strobe exactly the bits whose registered value is about to change.
    div_en_d = div_d ^ div_q;

    case (state_q)
      StIdle:     if (start && !stop) state_d = StRun;
      StRun:      if (stop) state_d = StStopping;
      StStopping: if (at_stop_phase || (tick && (div_d == StopPhase))) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      div_en_q   <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_en_q   <= div_en_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign signal_to_one_half    = div_q[0];
  assign one_half_pipe_enable  = div_en_q[0];
`ifdef ONE_FORTH_COUNTER_EN
  assign signal_to_one_forth   = div_q[1];
  assign one_forth_pipe_enable = div_en_q[1];
`endif
  assign running               = (state_q != StIdle);
  assign tick_count            = tick_cnt_q;

endmodule

// File: tb/tb_divider_counter.sv
// Directed bench for divider_counter: three instances (PRESCALE 4, 2, 1 with TICK_W 4).
module tb_divider_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: PRESCALE=4
  logic a_reset, a_start, a_stop, a_sclr, a_half, a_half_en, a_run;
  logic [15:0] a_tc;
  // Instance B: PRESCALE=2
  logic b_reset, b_start, b_stop, b_sclr, b_half, b_half_en, b_run;
  logic [15:0] b_tc;
  // Instance C: PRESCALE=1, TICK_W=4
  logic c_reset, c_start, c_stop, c_sclr, c_half, c_half_en, c_run;
  logic [3:0] c_tc;
`ifdef ONE_FORTH_COUNTER_EN
  logic a_forth, a_forth_en, b_forth, b_forth_en, c_forth, c_forth_en;
`endif

  divider_counter #(.PRESCALE(4), .PRESCALE_W(8), .TICK_W(16)) u_a (
    .clock(clock), .reset(a_reset), .start(a_start), .stop(a_stop), .sync_clear(a_sclr),
    .signal_to_one_half(a_half), .one_half_pipe_enable(a_half_en),
`ifdef ONE_FORTH_COUNTER_EN
    .signal_to_one_forth(a_forth), .one_forth_pipe_enable(a_forth_en),
`endif
    .running(a_run), .tick_count(a_tc)
  );

  divider_counter #(.PRESCALE(2), .PRESCALE_W(8), .TICK_W(16)) u_b (
    .clock(clock), .reset(b_reset), .start(b_start), .stop(b_stop), .sync_clear(b_sclr),
    .signal_to_one_half(b_half), .one_half_pipe_enable(b_half_en),
`ifdef ONE_FORTH_COUNTER_EN
    .signal_to_one_forth(b_forth), .one_forth_pipe_enable(b_forth_en),
`endif
    .running(b_run), .tick_count(b_tc)
  );

  divider_counter #(.PRESCALE(1), .PRESCALE_W(4), .TICK_W(4)) u_c (
    .clock(clock), .reset(c_reset), .start(c_start), .stop(c_stop), .sync_clear(c_sclr),
    .signal_to_one_half(c_half), .one_half_pipe_enable(c_half_en),
`ifdef ONE_FORTH_COUNTER_EN
    .signal_to_one_forth(c_forth), .one_forth_pipe_enable(c_forth_en),
`endif
    .running(c_run), .tick_count(c_tc)
  );

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    {a_reset, b_reset, c_reset} = 3'b111;
    {a_start, a_stop, a_sclr}   = '0;
    {b_start, b_stop, b_sclr}   = '0;
    {c_start, c_stop, c_sclr}   = '0;
    cyc(2);

    // ---------------- A: reset values, then start with PRESCALE=4
    chk_b("a_rst_half", a_half, 1'b0);
    chk_b("a_rst_en", a_half_en, 1'b0);
    chk_b("a_rst_run", a_run, 1'b0);
    chk_n("a_rst_tc", int'(a_tc), 0);
    a_reset = 1'b0;
    cyc();
    a_start = 1'b1;
    cyc();                                   // E0
    a_start = 1'b0;
    chk_b("a_run_e0", a_run, 1'b1);
    chk_b("a_half_e0", a_half, 1'b0);
    cyc(3);                                  // E3
    chk_b("a_half_e3", a_half, 1'b0);
    chk_b("a_en_e3", a_half_en, 1'b0);
    cyc();                                   // E4: first tick
    chk_b("a_half_e4", a_half, 1'b1);
    chk_b("a_en_e4", a_half_en, 1'b1);
    chk_n("a_tc_e4", int'(a_tc), 1);
    cyc();                                   // E5
    chk_b("a_en_e5", a_half_en, 1'b0);
    chk_b("a_half_e5", a_half, 1'b1);
    cyc(3);                                  // E8
    chk_b("a_half_e8", a_half, 1'b0);
    chk_b("a_en_e8", a_half_en, 1'b1);
    chk_n("a_tc_e8", int'(a_tc), 2);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("a_forth_e8", a_forth, 1'b1);
    chk_b("a_forth_en_e8", a_forth_en, 1'b1);
`endif
    cyc();                                   // E9
    chk_b("a_en_e9", a_half_en, 1'b0);
    cyc(3);                                  // E12
    chk_b("a_half_e12", a_half, 1'b1);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("a_forth_e12", a_forth, 1'b1);
    chk_b("a_forth_en_e12", a_forth_en, 1'b0);
`endif
    cyc(4);                                  // E16
    chk_b("a_half_e16", a_half, 1'b0);
    chk_n("a_tc_e16", int'(a_tc), 4);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("a_forth_e16", a_forth, 1'b0);
    chk_b("a_forth_en_e16", a_forth_en, 1'b1);
`endif
    cyc(4);                                  // E20: tick_count 5, one_half 1
    chk_n("a_tc_e20", int'(a_tc), 5);
    chk_b("a_half_e20", a_half, 1'b1);

    // sync_clear while running
    a_sclr = 1'b1;
    cyc();                                   // E21
    a_sclr = 1'b0;
    chk_n("a_sclr_tc", int'(a_tc), 0);
    chk_b("a_sclr_half", a_half, 1'b0);
    chk_b("a_sclr_en", a_half_en, 1'b1);
    chk_b("a_sclr_run", a_run, 1'b1);
    cyc();                                   // E22
    chk_b("a_sclr_en_drop", a_half_en, 1'b0);
    cyc(2);                                  // E24
    chk_b("a_sclr_half_e24", a_half, 1'b0);
    cyc();                                   // E25: next tick PRESCALE cycles after clear
    chk_b("a_sclr_half_e25", a_half, 1'b1);
    chk_n("a_sclr_tc_e25", int'(a_tc), 1);

    // asynchronous reset mid-cycle
    a_reset = 1'b1;
    #2;
    chk_b("a_arst_half", a_half, 1'b0);
    chk_b("a_arst_en", a_half_en, 1'b0);
    chk_b("a_arst_run", a_run, 1'b0);
    chk_n("a_arst_tc", int'(a_tc), 0);
    cyc();
    a_reset = 1'b0;
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    chk_b("a_rerun_run", a_run, 1'b1);
    chk_b("a_rerun_half0", a_half, 1'b0);
    cyc(3);
    chk_b("a_rerun_half3", a_half, 1'b0);
    cyc();
    chk_b("a_rerun_half4", a_half, 1'b1);
    chk_n("a_rerun_tc4", int'(a_tc), 1);

    // ---------------- B: start+stop together in IDLE, then stop behaviour (PRESCALE=2)
    b_reset = 1'b0;
    b_start = 1'b1;
    b_stop  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_b("b_both_run", b_run, 1'b0);
      chk_b("b_both_en", b_half_en, 1'b0);
`ifdef ONE_FORTH_COUNTER_EN
      chk_b("b_both_forth_en", b_forth_en, 1'b0);
`endif
    end
    b_stop = 1'b0;
    cyc();                                   // E0
    b_start = 1'b0;
    chk_b("b_run_e0", b_run, 1'b1);
    cyc(2);                                  // E2
    chk_b("b_half_e2", b_half, 1'b1);
    cyc(4);                                  // E6: half 1, forth 1
    chk_b("b_half_e6", b_half, 1'b1);
    chk_n("b_tc_e6", int'(b_tc), 3);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("b_forth_e6", b_forth, 1'b1);
`endif
    b_stop = 1'b1;
    cyc();                                   // E7: STOPPING
    b_stop = 1'b0;
    chk_b("b_stopping_run", b_run, 1'b1);
    chk_b("b_stopping_half", b_half, 1'b1);
    cyc();                                   // E8: final tick, running falls
    chk_b("b_stop_run", b_run, 1'b0);
    chk_b("b_stop_half", b_half, 1'b0);
    chk_b("b_stop_en", b_half_en, 1'b1);
    chk_n("b_stop_tc", int'(b_tc), 4);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("b_stop_forth", b_forth, 1'b0);
    chk_b("b_stop_forth_en", b_forth_en, 1'b1);
`endif
    cyc(4);
    chk_n("b_idle_tc", int'(b_tc), 4);
    chk_b("b_idle_half", b_half, 1'b0);
    chk_b("b_idle_run", b_run, 1'b0);

    // stop while already all-zero: no further ticks
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    chk_b("b_z_run0", b_run, 1'b1);
    b_stop = 1'b1;
    cyc();
    b_stop = 1'b0;
    chk_b("b_z_run1", b_run, 1'b1);
    cyc();
    chk_b("b_z_run2", b_run, 1'b0);
    chk_b("b_z_half2", b_half, 1'b0);
    chk_n("b_z_tc2", int'(b_tc), 4);
    cyc(3);
    chk_n("b_z_tc5", int'(b_tc), 4);

    // ---------------- C: PRESCALE=1, TICK_W=4 wrap and continuous enable
    c_reset = 1'b0;
    c_start = 1'b1;
    cyc();                                   // E0
    c_start = 1'b0;
    chk_b("c_run_e0", c_run, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk_n("c_tc", int'(c_tc), k % 16);
      chk_b("c_en", c_half_en, 1'b1);
      chk_b("c_half", c_half, logic'(k % 2));
    end
    c_stop = 1'b1;
    cyc();                                   // E18: RUN tick, enter STOPPING
    c_stop = 1'b0;
    chk_b("c_e18_run", c_run, 1'b1);
    chk_b("c_e18_half", c_half, 1'b0);
    chk_n("c_e18_tc", int'(c_tc), 2);
`ifdef ONE_FORTH_COUNTER_EN
    chk_b("c_e18_forth", c_forth, 1'b1);
    cyc();                                   // E19: one-forth still 1, keep ticking
    chk_b("c_e19_run", c_run, 1'b1);
    chk_b("c_e19_half", c_half, 1'b1);
    chk_n("c_e19_tc", int'(c_tc), 3);
    cyc();                                   // E20: 0/0 reached
    chk_b("c_e20_run", c_run, 1'b0);
    chk_b("c_e20_half", c_half, 1'b0);
    chk_b("c_e20_forth", c_forth, 1'b0);
    chk_n("c_e20_tc", int'(c_tc), 4);
`else
    cyc();                                   // E19: exits on one_half = 0 alone
    chk_b("c_e19_run", c_run, 1'b0);
    chk_b("c_e19_half", c_half, 1'b0);
    chk_n("c_e19_tc", int'(c_tc), 2);
`endif
    cyc(2);
    chk_b("c_idle_en", c_half_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_counter.md
# divider_counter

Upstream stage of the counter pipeline: generates the divide-by-2 (one-half) and divide-by-4 (one-forth) counter signals, plus a one-cycle pipe-enable strobe for each. These feed the pipeline register stage directly. A prescaler sets the tick rate, and a small run-control FSM starts, stops and phase-aligns the dividers so a stop always leaves the downstream stage holding zeros.

## Interface
- PRESCALE, 4: clock cycles per divider tick; legal range 1..2^PRESCALE_W-1.
- PRESCALE_W, 8: width of the prescale counter.
- TICK_W, 16: width of the free-running tick counter.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; all state is cleared immediately on assertion.
- start  in  1  level-sampled run request.
- stop  in  1  level-sampled stop request.
- sync_clear  in  1  resynchronise dividers while running.
- signal_to_one_half  out  1  divide-by-2 of tick; consumed as signal_from_one_half.
- one_half_pipe_enable  out  1  one-cycle strobe: new one-half value valid.
- signal_to_one_forth  out  1  divide-by-4 of tick; present only with ONE_FORTH_COUNTER_EN.
- one_forth_pipe_enable  out  1  one-cycle strobe for the one-forth value; present only with ONE_FORTH_COUNTER_EN.
- running  out  1  high in RUN and STOPPING.
- tick_count  out  TICK_W  number of ticks since the last reset or sync_clear; wraps modulo 2^TICK_W.

## Operation
- Reset values: every output is 0, FSM is in IDLE, and the prescale counter is 0.
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: stop moves to STOPPING.
  - STOPPING: returns to IDLE once all divider outputs are 0 after a tick.
- Prescaler:
  - Counts 0..PRESCALE-1 in RUN and STOPPING, and is held at 0 in IDLE.
  - A tick is the cycle in which count == PRESCALE-1; the count then wraps to 0.
- On each tick:
  - signal_to_one_half toggles.
  - signal_to_one_forth toggles when signal_to_one_half goes 1→0.
  - tick_count increments.
- Pipe enables:
  - Each enable is registered and is high exactly for the cycle in which its toggled value is first visible.
  - An enable stays low on ticks where its signal does not change.
- STOPPING keeps ticking until the outputs reach the all-zero phase:
  - with the macro: one-half = 0 and one-forth = 0;
  - without it: one-half = 0.
- stop arriving while the outputs are already all-zero goes RUN → STOPPING → IDLE, with no further ticks.
- start in RUN or STOPPING is ignored.
- stop in IDLE is ignored.
- start and stop together in IDLE: stop wins, FSM stays IDLE.
- sync_clear in RUN:
  - Next cycle: prescaler = 0, tick_count = 0, divider outputs = 0.
  - Any divider output that changed gets its enable pulsed for 1 cycle.
  - FSM stays in RUN.
  - sync_clear is ignored in IDLE and STOPPING.
- Reset asserted mid-run forces the reset values asynchronously and discards any pending tick.

## Timing
- start sampled high at edge N → running = 1 after edge N+1, prescaler = 0.
- First tick → one_half = 1 and enable high, visible after edge N+1+PRESCALE.
- PRESCALE = 1: a tick every cycle, so one_half_pipe_enable is continuously high while running.
- Output periods: one-half period = 2·PRESCALE cycles; one-forth period = 4·PRESCALE cycles.
- Enable-to-data latency is 0: strobe and new value appear on the same edge, so the downstream register captures at the following edge.
- running falls on the same edge that makes the final output zero.

## Configuration
- ONE_FORTH_COUNTER_EN defined: the one-forth divider, its ports and its term in the STOPPING exit condition are all compiled in.
- ONE_FORTH_COUNTER_EN undefined:
  - signal_to_one_forth and one_forth_pipe_enable do not exist.
  - STOPPING exits on one-half = 0 alone.
  - All other behaviour is identical.

## Structure
- divider_counter_pkg holds:
  - the FSM state enum (IDLE, RUN, STOPPING);
  - the default PRESCALE, PRESCALE_W and TICK_W constants;
  - a helper constant for the all-zero stop phase.
- Sub-module divider_prescaler:
  - counter with clear and enable;
  - outputs the single-cycle tick.
- The FSM, dividers, enables and tick_count stay in divider_counter.

## Test plan
- Reset then start (PRESCALE = 4):
  - one_half rises 4 cycles after running = 1, then toggles every 4 cycles;
  - each toggle comes with a 1-cycle enable;
  - one-forth toggles every 8 cycles.
- stop issued when one_half = 1 and one_forth = 1 (PRESCALE = 2): exactly 1 more tick, outputs 0/0, running falls on that edge, FSM returns to IDLE.
- start and stop together in IDLE → running stays 0 and no enables fire for 20 cycles.
- sync_clear at tick_count = 5 with one_half = 1: next cycle tick_count = 0, one_half = 0, one_half_pipe_enable = 1 for one cycle, next tick comes PRESCALE cycles later.
- Reset asserted mid-cycle while running → all outputs 0 immediately, without waiting for a clock edge; a start after reset release runs again from phase 0.
- TICK_W = 4 with PRESCALE = 1, run 17 cycles:
  - tick_count wraps 15 → 0;
  - one_half_pipe_enable stays continuously high;
  - repeat the build without ONE_FORTH_COUNTER_EN and confirm stop exits on one_half = 0.
